// File: rtl/pid_pkg.sv
// ============================================================================
// Module      : pid_pkg
// Description : Shared width, saturation bounds and FSM state type for the
//               PID error stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pid_pkg;

    localparam int PID_W = 6;

    // Flag positions inside sat_flags {d,i,p}
    localparam int FLAG_P = 0;
    localparam int FLAG_I = 1;
    localparam int FLAG_D = 2;

    function automatic int sat_max_f(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min_f(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam logic signed [PID_W-1:0] SAT_MAX = PID_W'(sat_max_f(PID_W));
    localparam logic signed [PID_W-1:0] SAT_MIN = PID_W'(sat_min_f(PID_W));

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_PRESENT = 2'd2
    } pid_state_e;

endpackage

`default_nettype wire

// File: rtl/pid_error_stage_if.sv
// ============================================================================
// Module      : pid_error_stage_if
// Description : Sample-in / terms-out handshake bundle of the PID error stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pid_error_stage_if
    import pid_pkg::*;
#(
    parameter int W = PID_W
) ();

    logic signed [W-1:0] setpoint;
    logic signed [W-1:0] feedback;
    logic                sample_valid;
    logic                sample_ready;
    logic signed [W-1:0] err_p;
    logic signed [W-1:0] err_i;
    logic signed [W-1:0] err_d;
    logic                out_valid;
    logic                mult_ready;
    logic [2:0]          sat_flags;

    modport master (
        output setpoint, feedback, sample_valid, mult_ready,
        input  sample_ready, err_p, err_i, err_d, out_valid, sat_flags
    );

    modport slave (
        input  setpoint, feedback, sample_valid, mult_ready,
        output sample_ready, err_p, err_i, err_d, out_valid, sat_flags
    );

endinterface

`default_nettype wire

// File: rtl/sat_addsub.sv
// ============================================================================
// Module      : sat_addsub
// Description : W-bit signed add/subtract evaluated at W+1 bits, clamped to
//               the W-bit signed range, with a clamp indicator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_addsub
    import pid_pkg::*;
#(
    parameter int W = PID_W
) (
    input  wire logic signed [W-1:0] a_i,
    input  wire logic signed [W-1:0] b_i,
    input  wire logic                sub_i,
    output logic signed [W-1:0]      y_o,
    output logic                     ovf_o
);

    localparam logic signed [W:0] c_HI = (W+1)'(sat_max_f(W));
    localparam logic signed [W:0] c_LO = (W+1)'(sat_min_f(W));

    logic signed [W:0] w_a_x;
    logic signed [W:0] w_b_x;
    logic signed [W:0] w_r_x;
    logic              w_hi;
    logic              w_lo;

    always_comb begin
        w_a_x = {a_i[W-1], a_i};
        w_b_x = {b_i[W-1], b_i};
        w_r_x = sub_i ? (w_a_x - w_b_x) : (w_a_x + w_b_x);
        w_hi  = (w_r_x > c_HI);
        w_lo  = (w_r_x < c_LO);
        ovf_o = w_hi | w_lo;
        if (w_hi) begin
            y_o = c_HI[W-1:0];
        end else if (w_lo) begin
            y_o = c_LO[W-1:0];
        end else begin
            y_o = w_r_x[W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/pid_error_stage.sv
// ============================================================================
// Module      : pid_error_stage
// Description : Forms saturated P, I and D error terms from a setpoint /
//               feedback pair and hands them to the multiplier stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_error_stage
    import pid_pkg::*;
#(
    parameter int W = PID_W
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           ena,
    input  wire logic           int_clr,
    pid_error_stage_if.slave    bus
);

    pid_state_e          state_q;
    logic signed [W-1:0] err_p_q;
    logic signed [W-1:0] err_i_q;
    logic signed [W-1:0] err_d_q;
    logic signed [W-1:0] e_prev_q;
    logic                out_valid_q;
    logic                sample_ready_q;
    logic [2:0]          sat_flags_q;

    logic signed [W-1:0] w_e;
    logic signed [W-1:0] w_i_sum;
    logic signed [W-1:0] w_d_diff;
    logic signed [W-1:0] w_d_ref;
    logic                w_ovf_p;
    logic                w_ovf_i;
    logic                w_ovf_d;
    logic [2:0]          w_flags_base;

    // A clear in COMPUTE makes the derivative reference zero for this sample.
    assign w_d_ref      = int_clr ? '0 : e_prev_q;
    assign w_flags_base = int_clr ? 3'b000 : sat_flags_q;

    sat_addsub #(.W(W)) u_sat_p (
        .a_i   (bus.setpoint),
        .b_i   (bus.feedback),
        .sub_i (1'b1),
        .y_o   (w_e),
        .ovf_o (w_ovf_p)
    );

    sat_addsub #(.W(W)) u_sat_i (
        .a_i   (err_i_q),
        .b_i   (err_p_q),
        .sub_i (1'b0),
        .y_o   (w_i_sum),
        .ovf_o (w_ovf_i)
    );

    sat_addsub #(.W(W)) u_sat_d (
        .a_i   (err_p_q),
        .b_i   (w_d_ref),
        .sub_i (1'b1),
        .y_o   (w_d_diff),
        .ovf_o (w_ovf_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            err_p_q        <= '0;
            err_i_q        <= '0;
            err_d_q        <= '0;
            e_prev_q       <= '0;
            out_valid_q    <= 1'b0;
            sample_ready_q <= 1'b1;
            sat_flags_q    <= 3'b000;
        end else if (ena) begin
            if (int_clr) begin
                err_i_q     <= '0;
                e_prev_q    <= '0;
                sat_flags_q <= 3'b000;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.sample_valid) begin
                        err_p_q        <= w_e;
                        sat_flags_q    <= w_flags_base | {1'b0, 1'b0, w_ovf_p};
                        sample_ready_q <= 1'b0;
                        state_q        <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    err_d_q     <= w_d_diff;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_PRESENT;
                    if (!int_clr) begin
                        err_i_q     <= w_i_sum;
                        e_prev_q    <= err_p_q;
                        sat_flags_q <= sat_flags_q | {w_ovf_d, w_ovf_i, 1'b0};
                    end
                end
                ST_PRESENT: begin
                    if (bus.mult_ready) begin
                        out_valid_q    <= 1'b0;
                        sample_ready_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q    <= 1'b0;
                    sample_ready_q <= 1'b1;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.err_p        = err_p_q;
    assign bus.err_i        = err_i_q;
    assign bus.err_d        = err_d_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.sample_ready = sample_ready_q;
    assign bus.sat_flags    = sat_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_pid_error_stage.sv
// ============================================================================
// Module      : tb_pid_error_stage
// Description : Directed self-checking bench for pid_error_stage (W=6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_error_stage;
    import pid_pkg::*;

    localparam int W = PID_W;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic int_clr;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pid_error_stage_if #(.W(W)) bus ();

    pid_error_stage #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .int_clr (int_clr),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_terms(input string tag, input int ep, input int ei,
                             input int ed, input int ov, input int fl);
        chk({tag, ".err_p"}, bus.err_p, ep);
        chk({tag, ".err_i"}, bus.err_i, ei);
        chk({tag, ".err_d"}, bus.err_d, ed);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, ov);
        chk({tag, ".sat_flags"}, {29'd0, bus.sat_flags}, fl);
    endtask

    // Full transaction: accept, compute, present, release.
    task automatic sample(input string tag, input int sp, input int fb,
                          input int ep, input int ei, input int ed, input int fl);
        bus.setpoint     = W'(sp);
        bus.feedback     = W'(fb);
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk({tag, ".accept_p"}, bus.err_p, ep);
        chk({tag, ".ov_early"}, {31'd0, bus.out_valid}, 0);
        tick();
        chk_terms(tag, ep, ei, ed, 1, fl);
        chk({tag, ".ready_busy"}, {31'd0, bus.sample_ready}, 0);
        bus.mult_ready = 1'b1;
        tick();
        bus.mult_ready = 1'b0;
        chk({tag, ".ov_release"}, {31'd0, bus.out_valid}, 0);
        chk({tag, ".ready_idle"}, {31'd0, bus.sample_ready}, 1);
    endtask

    task automatic clear();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        chk("clear.err_i", bus.err_i, 0);
        chk("clear.flags", {29'd0, bus.sat_flags}, 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        ena              = 1'b1;
        int_clr          = 1'b0;
        bus.setpoint     = '0;
        bus.feedback     = '0;
        bus.sample_valid = 1'b0;
        bus.mult_ready   = 1'b0;
        tick();
        tick();
        chk_terms("reset", 0, 0, 0, 0, 0);
        chk("reset.ready", {31'd0, bus.sample_ready}, 1);
        rst_n = 1'b1;
        tick();

        // Basic sample
        sample("basic", 10, 3, 7, 7, 7, 0);

        // P clamp then I clamp
        clear();
        sample("psat1", 31, -32, 31, 31, 31, 1);
        sample("psat2", 31, -32, 31, 31, 0, 3);

        // Negative P and D clamps after e=20
        clear();
        sample("pre20", 20, 0, 20, 20, 20, 0);
        sample("negsat", -32, 31, -32, -12, -32, 5);

        // Back-pressure in PRESENT
        clear();
        bus.setpoint = 6'sd5; bus.feedback = 6'sd1; bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        tick();
        chk_terms("hold0", 4, 4, 4, 1, 0);
        bus.setpoint = 6'sd9; bus.feedback = 6'sd0; bus.sample_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_terms("hold", 4, 4, 4, 1, 0);
            chk("hold.ready", {31'd0, bus.sample_ready}, 0);
        end
        bus.sample_valid = 1'b0;
        bus.mult_ready   = 1'b1;
        tick();
        bus.mult_ready = 1'b0;
        chk("hold.release_ov", {31'd0, bus.out_valid}, 0);
        chk("hold.release_ready", {31'd0, bus.sample_ready}, 1);
        tick();
        chk("hold.not_queued", bus.err_p, 4);
        chk("hold.still_ready", {31'd0, bus.sample_ready}, 1);

        // int_clr during COMPUTE
        clear();
        sample("clr_a", 31, -32, 31, 31, 31, 1);
        sample("clr_b", -11, 0, -11, 20, -32, 5);
        bus.setpoint = 6'sd5; bus.feedback = 6'sd0; bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        chk_terms("clr_compute", 5, 0, 5, 1, 0);
        bus.mult_ready = 1'b1;
        tick();
        bus.mult_ready = 1'b0;
        sample("clr_after", 3, 0, 3, 3, 3, 0);

        // Asynchronous reset mid-COMPUTE
        bus.setpoint = 6'sd6; bus.feedback = 6'sd2; bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk("rst.pre_p", bus.err_p, 4);
        #2 rst_n = 1'b0;
        #1;
        chk_terms("rst.async", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        chk("rst.ready", {31'd0, bus.sample_ready}, 1);
        tick();
        chk_terms("rst.after", 0, 0, 0, 0, 0);

        // ena low in IDLE blocks acceptance
        ena = 1'b0;
        bus.setpoint = 6'sd7; bus.feedback = 6'sd0; bus.sample_valid = 1'b1;
        tick();
        tick();
        chk("ena_idle.p", bus.err_p, 0);
        chk("ena_idle.ready", {31'd0, bus.sample_ready}, 1);
        ena = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        chk("ena_idle.accept", bus.err_p, 7);
        tick();
        chk_terms("ena_present", 7, 7, 7, 1, 0);

        // ena low in PRESENT freezes everything
        ena = 1'b0;
        bus.mult_ready = 1'b1;
        int_clr = 1'b1;
        bus.setpoint = 6'sd1; bus.sample_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_terms("ena_frozen", 7, 7, 7, 1, 0);
            chk("ena_frozen.ready", {31'd0, bus.sample_ready}, 0);
        end
        int_clr = 1'b0;
        bus.sample_valid = 1'b0;
        ena = 1'b1;
        tick();
        bus.mult_ready = 1'b0;
        chk("ena_resume.ov", {31'd0, bus.out_valid}, 0);
        chk("ena_resume.ready", {31'd0, bus.sample_ready}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pid_error_stage.md
PID_ERROR_STAGE -- requirements
Module: pid_error_stage

Interface
REQ-001 SHALL have parameter W, default 6, data width of all signed samples and outputs.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have port ena, input, 1, global enable; low freezes all state and outputs.
REQ-005 SHALL have port setpoint, input, W signed, target value.
REQ-006 SHALL have port feedback, input, W signed, measured plant value.
REQ-007 SHALL have port sample_valid, input, 1, setpoint/feedback pair offered.
REQ-008 SHALL have port sample_ready, output, 1, block can accept a sample.
REQ-009 SHALL have port int_clr, input, 1, synchronous clear of integral and previous error.
REQ-010 SHALL have port err_p, output, W signed, proportional term e for the multiplier stage.
REQ-011 SHALL have port err_i, output, W signed, saturated running integral of e.
REQ-012 SHALL have port err_d, output, W signed, saturated difference e minus e_prev.
REQ-013 SHALL have port out_valid, output, 1, err_p/err_i/err_d valid for the multiplier stage.
REQ-014 SHALL have port mult_ready, input, 1, multiplier stage accepts the presented terms.
REQ-015 SHALL have port sat_flags, output, 3, sticky saturation indicators {d,i,p}.

Function
REQ-016 SHALL implement FSM states IDLE, COMPUTE and PRESENT; all transitions require ena=1.
REQ-017 SHALL hold sample_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE with sample_valid=1, latch e = sat(setpoint - feedback) into err_p and move to COMPUTE.
REQ-019 SHALL, in COMPUTE, set err_i = sat(err_i + e), set err_d = sat(e - e_prev), set e_prev = e, assert out_valid and move to PRESENT.
REQ-020 SHALL, in PRESENT, hold out_valid and all terms stable until mult_ready=1, then clear out_valid and return to IDLE on that edge.
REQ-021 SHALL assert out_valid exactly 2 clk edges after the accepting edge when ena stays high.
REQ-022 SHALL compute all differences and sums at W+1 bits, then saturate to [-2^(W-1), 2^(W-1)-1], i.e. [-32, 31] for W=6; wrap-around is forbidden.
REQ-023 SHALL set the matching sat_flags bit whenever a clamp occurs; bits clear only on reset or int_clr.
REQ-024 SHALL, when int_clr=1, zero err_i, e_prev and sat_flags on that edge; in COMPUTE, err_i becomes 0 instead of e, and err_d becomes e - 0.
REQ-025 SHALL ignore sample_valid outside IDLE; samples are neither queued nor dropped silently (the upstream source keeps sample_valid held).
REQ-026 SHALL, with ena=0 in any state, keep state, terms, out_valid and sample_ready unchanged.
REQ-027 SHALL treat mult_ready=1 in IDLE or COMPUTE as a no-op.

Reset
REQ-028 SHALL, on rst_n low, immediately force the state to IDLE, set err_p, err_i, err_d, e_prev and sat_flags to 0, and set out_valid to 0.
REQ-029 SHALL abandon any in-flight sample when reset asserts mid-operation; on release, sample_ready=1 on the first cycle.

Structure
REQ-030 SHALL take W, the SAT_MAX/SAT_MIN constants and the state enum from the shared package pid_pkg.
REQ-031 SHALL instantiate a sub-module sat_addsub (W-bit signed add/sub with saturation and an overflow flag) three times, once each for p, i and d.

Verification
REQ-032 SHALL test setpoint=10, feedback=3: expect err_p=7, err_i=7 and err_d=7 on the first sample; out_valid 2 edges after acceptance.
REQ-033 SHALL test setpoint=31, feedback=-32: expect err_p=31 and sat_flags[0]=1; a second identical sample gives err_i=31, sat_flags[1]=1 and err_d=0.
REQ-034 SHALL test setpoint=-32, feedback=31 after a prior e=20: expect err_p=-32 and err_d=-32 (clamped from -52), with sat_flags[2]=1.
REQ-035 SHALL test mult_ready held low for 5 cycles in PRESENT: expect terms and out_valid stable, sample_ready=0 and a new sample ignored; a mult_ready pulse returns the FSM to IDLE.
REQ-036 SHALL test int_clr asserted during COMPUTE with e=5 and prior err_i=20: expect err_i=5 is not produced, err_i=0, err_d=5 and sat_flags=0.
REQ-037 SHALL test rst_n asserted mid-COMPUTE and ena toggled low in PRESENT: expect all outputs 0 asynchronously, and no state change while ena=0.
